cacheline_burst_adapter: RTL
============================

Name: cacheline_burst_adapter

Overview:
- Memory-side responder for the cache arbiter's single cacheline port. Accepts one cacheline read or write request (address, read/write strobes, full-line write data) and answers with line_resp.
- Converts each request into a burst of narrow beats on the physical-memory burst interface.
- On reads, assembles the returned beats into a registered line buffer. On writes, serializes the latched line into beats.
- One outstanding transaction at a time.

Parameters:
- s_offset, 5, log2 of cacheline size in bytes.
- size, (2**s_offset)*8, cacheline width in bits (256 at default).
- beat_width, 64, burst data width in bits. size must be an integer multiple of beat_width.
- beats, size/beat_width, beats per burst (4 at default).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- line_address  in  32  requested cacheline address from arbiter.
- line_read  in  1  cacheline read request, held until line_resp.
- line_write  in  1  cacheline write request, held until line_resp.
- line_wdata  in  size  cacheline write data.
- line_rdata  out  size  assembled read line. Registered, stable until the next read completes.
- line_resp  out  1  one-cycle completion pulse.
- burst_address  out  32  line-aligned burst address.
- burst_read  out  1  burst read request.
- burst_write  out  1  burst write request.
- burst_wdata  out  beat_width  current write beat.
- burst_rdata  in  beat_width  returned read beat, valid when burst_resp=1.
- burst_resp  in  1  per-beat acknowledge.

Behaviour:
- Reset (rst_n=0, async): state IDLE, beat counter 0, all buffers 0. All outputs 0, including line_rdata, line_resp, burst_read, burst_write, burst_address and burst_wdata. A reset mid-transaction abandons the burst immediately; no line_resp is issued.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - line_write=1 -> latch line_address with the low s_offset bits forced to 0, latch line_wdata, counter=0, go WRITE.
  - Else line_read=1 -> latch the aligned address, counter=0, go READ.
  - If both are asserted, write wins.
  - burst_resp is ignored in IDLE.
- READ:
  - burst_read=1 and burst_address=latched address.
  - On each cycle with burst_resp=1, store burst_rdata into line buffer slice [counter*beat_width +: beat_width] and increment counter. Beat 0 goes to the LSBs.
  - Cycles with burst_resp=0 are stalls: no change.
  - When the last beat (counter=beats-1) is accepted, go DONE.
- WRITE:
  - burst_write=1, burst_address=latched address, burst_wdata = latched line slice [counter*beat_width +: beat_width].
  - Each burst_resp=1 advances counter.
  - The last beat's resp -> DONE.
- DONE:
  - line_resp=1 for exactly this cycle; burst_read and burst_write are 0.
  - On reads, line_rdata already holds the full line this cycle.
  - Next state is always IDLE, so at least one cycle separates back-to-back transactions.
- Latency: request seen in IDLE at cycle T; burst strobe asserted from T+1; line_resp asserted the cycle after the last burst_resp. Minimum read/write latency is beats+2 cycles.
- Request inputs (address, data, strobes) that change after acceptance are ignored until IDLE.
- A line_rdata register update occurs only on read beats. Writes never disturb line_rdata.
- Counter width is clog2(beats). It resets to 0 on every acceptance and never wraps within a burst.

Test Plan:
- Read at 0x0000_1234, memory returns beats 0x1111111111111111, 0x2222…, 0x3333…, 0x4444… on consecutive cycles -> burst_address=0x0000_1220, line_resp one cycle after the 4th beat, line_rdata=0x4444…_3333…_2222…_1111….
- Write at 0x0000_8040 with line_wdata={D3,D2,D1,D0} -> burst_write high with burst_wdata sequencing D0,D1,D2,D3 on successive burst_resp, then one line_resp pulse, then burst_write=0.
- Read with memory inserting 2 stall cycles between beats 1 and 2 -> data unchanged from the no-stall case, line_resp delayed by exactly 2 cycles.
- rst_n pulled low during read beat 2 -> burst_read drops without waiting for clk, no line_resp, line_rdata=0. A subsequent full read completes correctly.
- line_read and line_write asserted together -> write burst performed first, line_resp once. After IDLE, a held line_read starts a read burst.
- burst_resp pulsed while IDLE -> no state change, no line_resp, line_rdata unchanged.

Source files
------------

// File: rtl/cacheline_burst_adapter_if.sv
// Purpose: bundles the cacheline-side and burst-side signals of the burst adapter.
// Latency: none, wiring only.
// Backpressure: burst_resp paces beats; line_resp completes the held line request.
interface cacheline_burst_adapter_if #(
  parameter int size       = 256,
  parameter int beat_width = 64
);
  logic [31:0]           line_address;
  logic                  line_read;
  logic                  line_write;
  logic [size-1:0]       line_wdata;
  logic [size-1:0]       line_rdata;
  logic                  line_resp;
  logic [31:0]           burst_address;
  logic                  burst_read;
  logic                  burst_write;
  logic [beat_width-1:0] burst_wdata;
  logic [beat_width-1:0] burst_rdata;
  logic                  burst_resp;

  // Adapter side: answers line requests, drives the burst port.
  modport slave (
    input  line_address, line_read, line_write, line_wdata,
    output line_rdata, line_resp,
    output burst_address, burst_read, burst_write, burst_wdata,
    input  burst_rdata, burst_resp
  );

  // Environment side: arbiter plus physical memory.
  modport master (
    output line_address, line_read, line_write, line_wdata,
    input  line_rdata, line_resp,
    input  burst_address, burst_read, burst_write, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Purpose: turns one cacheline read/write into a burst of narrow beats, one transaction at a time.
// Latency: strobe from the cycle after acceptance; line_resp the cycle after the last beat (min beats+2).
// Backpressure: burst_resp=0 stalls the burst; line strobes are held by the requester until line_resp.
module cacheline_burst_adapter #(
  parameter int s_offset   = 5,
  parameter int size       = (2**s_offset)*8,
  parameter int beat_width = 64,
  parameter int beats      = size/beat_width
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cacheline_burst_adapter_if.slave bus
);

  localparam int CW = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [CW-1:0] LAST_BEAT  = CW'(beats-1);
  localparam logic [31:0]   ALIGN_MASK = ~((32'd1 << s_offset) - 32'd1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [31:0]     addr_q,  addr_d;
  logic [size-1:0] wbuf_q,  wbuf_d;
  logic [size-1:0] rbuf_q,  rbuf_d;

  // Next-state: accept in IDLE (write has priority), step one beat per burst_resp.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      IDLE: begin
        if (bus.line_write) begin
          addr_d  = bus.line_address & ALIGN_MASK;
          wbuf_d  = bus.line_wdata;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (bus.line_read) begin
          addr_d  = bus.line_address & ALIGN_MASK;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (bus.burst_resp) begin
          rbuf_d[cnt_q*beat_width +: beat_width] = bus.burst_rdata;
          // Hold the counter on the last beat so it never wraps inside a burst.
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (bus.burst_resp) begin
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and buffer registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them without a clock.
  assign bus.burst_read    = (state_q == READ);
  assign bus.burst_write   = (state_q == WRITE);
  assign bus.burst_address = addr_q;
  assign bus.burst_wdata   = (state_q == WRITE) ? wbuf_q[cnt_q*beat_width +: beat_width]
                                                : '0;
  assign bus.line_resp     = (state_q == DONE);
  assign bus.line_rdata    = rbuf_q;

endmodule
